sr_latch_driver: RTL and testbench

//  Sequential driver for a gated SR (NOR) latch. Takes target bits via valid/ready,

---
 rtl/sr_latch_driver.sv | 133 +++++++++++++
 tb/tb_sr_latch_driver.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/sr_latch_driver.sv
// Sequential driver for a gated SR (NOR) latch: accepts target bits, issues
// timed S/R pulses, verifies q feedback and retries on mismatch.
module sr_latch_driver #(
    parameter int unsigned PULSE_CYCLES  = 2,
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter int unsigned MAX_RETRY     = 3,
    parameter int unsigned CNT_W         = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic d_in,
    input  logic d_valid,
    output logic d_ready,
    input  logic q_fb,
    output logic s,
    output logic r,
    output logic busy,
    output logic done,
    output logic err
);

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        PULSE,
        SETTLE,
        CHECK
    } state_t;

    state_t             state_q, state_d;
    logic               target_q, target_d;
    logic               init_q, init_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   retry_q, retry_d;
    logic               s_d, r_d, d_ready_d, busy_d, done_d, err_d;

    // State, bookkeeping and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= INIT;
            target_q <= 1'b0;
            init_q   <= 1'b0;
            cnt_q    <= '0;
            retry_q  <= '0;
            s        <= 1'b0;
            r        <= 1'b0;
            d_ready  <= 1'b0;
            busy     <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            init_q   <= init_d;
            cnt_q    <= cnt_d;
            retry_q  <= retry_d;
            s        <= s_d;
            r        <= r_d;
            d_ready  <= d_ready_d;
            busy     <= busy_d;
            done     <= done_d;
            err      <= err_d;
        end
    end

    // Next-state logic; outputs are decoded from the next state so they are
    // valid in the first cycle of each state.
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        init_d   = init_q;
        cnt_d    = cnt_q;
        retry_d  = retry_q;
        done_d   = 1'b0;
        err_d    = err;

        unique case (state_q)
            INIT: begin
                target_d = 1'b0;
                init_d   = 1'b1;
                retry_d  = '0;
                cnt_d    = '0;
                state_d  = PULSE;
            end
            IDLE: begin
                if (d_valid && d_ready) begin
                    target_d = d_in;
                    init_d   = 1'b0;
                    retry_d  = '0;
                    cnt_d    = '0;
                    state_d  = (d_in == q_fb) ? CHECK : PULSE;
                end
            end
            PULSE: begin
                if (cnt_q == CNT_W'(PULSE_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = SETTLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SETTLE: begin
                if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = CHECK;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            CHECK: begin
                if (q_fb == target_q) begin
                    state_d = IDLE;
                    done_d  = ~init_q;
                end else if (retry_q < CNT_W'(MAX_RETRY)) begin
                    retry_d = retry_q + CNT_W'(1);
                    cnt_d   = '0;
                    state_d = PULSE;
                end else begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                    done_d  = ~init_q;
                end
            end
            default: state_d = INIT;
        endcase

        s_d       = (state_d == PULSE) &  target_d;
        r_d       = (state_d == PULSE) & ~target_d;
        d_ready_d = (state_d == IDLE);
        busy_d    = (state_d != IDLE);
    end

endmodule

// File: tb/tb_sr_latch_driver.sv
// Bench for sr_latch_driver: NOR-latch model, directed scenarios, then random
// traffic scored against a transaction-level latency/pulse model.
module tb_sr_latch_driver;

    localparam int unsigned PC = 2;
    localparam int unsigned SC = 1;
    localparam int unsigned MR = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic d_in = 1'b0;
    logic d_valid = 1'b0;
    logic q_fb, s, r, d_ready, busy, done, err;
    logic q_latch = 1'b1;
    logic stuck = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int s_pulses = 0, r_pulses = 0, s_cyc = 0, r_cyc = 0, busy_cyc = 0, done_cnt = 0;
    logic s_prev = 1'b0, r_prev = 1'b0;
    logic q_model;

    sr_latch_driver #(
        .PULSE_CYCLES (PC),
        .SETTLE_CYCLES(SC),
        .MAX_RETRY    (MR),
        .CNT_W        (4)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .d_in   (d_in),
        .d_valid(d_valid),
        .d_ready(d_ready),
        .q_fb   (q_fb),
        .s      (s),
        .r      (r),
        .busy   (busy),
        .done   (done),
        .err    (err)
    );

    always #5 clk = ~clk;

    // Latch model: set dominates nothing since s&r is checked illegal
    always @(posedge clk) begin
        if (s) q_latch <= 1'b1;
        else if (r) q_latch <= 1'b0;
    end
    assign q_fb = stuck ? 1'b0 : q_latch;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (s) s_cyc++;
        if (r) r_cyc++;
        if (busy) busy_cyc++;
        if (done) done_cnt++;
        if (s && !s_prev) s_pulses++;
        if (r && !r_prev) r_pulses++;
        s_prev = s;
        r_prev = r;
        chk("s_and_r", 32'(s & r), 0);
    endtask

    function automatic int exp_latency(input int attempts);
        return (attempts == 0) ? 2 : attempts * int'(PC + SC + 1) + 1;
    endfunction

    // Releases reset and checks the INIT r pulse and ready timing
    task automatic release_and_check_init(input string tag);
        int rp0;
        int dn0;
        rp0 = r_pulses;
        dn0 = done_cnt;
        rst = 1'b0;
        for (int k = 1; k <= int'(PC + SC + 2); k++) begin
            tick();
            chk({tag, "_r"}, 32'(r), 32'(k <= int'(PC)));
            chk({tag, "_s"}, 32'(s), 0);
            chk({tag, "_ready"}, 32'(d_ready), 32'(k == int'(PC + SC + 2)));
        end
        chk({tag, "_rpulses"}, 32'(r_pulses - rp0), 1);
        chk({tag, "_nodone"}, 32'(done_cnt - dn0), 0);
        chk({tag, "_q"}, 32'(q_fb), 0);
        chk({tag, "_err"}, 32'(err), 0);
        q_model = 1'b0;
    endtask

    task automatic do_write(input string tag, input logic d, input int attempts, input logic q_exp);
        int c0, sp0, rp0, sc0, rc0, b0, dn0;
        for (int i = 0; i < 50 && !d_ready; i++) tick();
        chk({tag, "_pre_ready"}, 32'(d_ready), 1);
        sp0 = s_pulses; rp0 = r_pulses; sc0 = s_cyc; rc0 = r_cyc; b0 = busy_cyc; dn0 = done_cnt;
        c0 = cyc;
        d_in = d;
        d_valid = 1'b1;
        tick();
        d_valid = 1'b0;
        d_in = $urandom_range(0, 1);
        for (int i = 0; i < 200 && !done; i++) tick();
        chk({tag, "_latency"}, 32'(cyc - c0), 32'(exp_latency(attempts)));
        chk({tag, "_done_ready"}, 32'(d_ready), 1);
        chk({tag, "_s_pulses"}, 32'(s_pulses - sp0), d ? 32'(attempts) : 0);
        chk({tag, "_r_pulses"}, 32'(r_pulses - rp0), d ? 0 : 32'(attempts));
        chk({tag, "_s_cycles"}, 32'(s_cyc - sc0), d ? 32'(attempts * int'(PC)) : 0);
        chk({tag, "_r_cycles"}, 32'(r_cyc - rc0), d ? 0 : 32'(attempts * int'(PC)));
        chk({tag, "_busy_cycles"}, 32'(busy_cyc - b0), 32'(exp_latency(attempts) - 1));
        chk({tag, "_q"}, 32'(q_fb), 32'(q_exp));
        tick();
        chk({tag, "_one_done"}, 32'(done_cnt - dn0), 1);
    endtask

    int exp_done_q[$];
    logic exp_val_q[$];
    int accepts, exp_pulses, p0, dn0, budget, att, edc;
    logic acc, ev;

    initial begin
        // Reset values
        repeat (3) tick();
        chk("rst_s", 32'(s), 0);
        chk("rst_r", 32'(r), 0);
        chk("rst_ready", 32'(d_ready), 0);
        chk("rst_busy", 32'(busy), 1);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        release_and_check_init("init1");

        // Set from 0, then same-value skip
        do_write("w1", 1'b1, 1, 1'b1);
        chk("w1_err", 32'(err), 0);
        q_model = 1'b1;
        do_write("w1skip", 1'b1, 0, 1'b1);

        // Stuck latch exhausts retries, err sticky across later good write
        stuck = 1'b1;
        do_write("stuck", 1'b1, int'(MR) + 1, 1'b0);
        chk("stuck_err", 32'(err), 1);
        stuck = 1'b0;
        do_write("after_stuck", 1'b0, 1, 1'b0);
        chk("sticky_err", 32'(err), 1);
        rst = 1'b1;
        tick();
        chk("rst_clears_err", 32'(err), 0);
        release_and_check_init("init2");

        // Reset asserted mid-pulse
        d_in = 1'b1;
        d_valid = 1'b1;
        tick();
        d_valid = 1'b0;
        chk("mid_s_high", 32'(s), 1);
        dn0 = done_cnt;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_s_drop", 32'(s), 0);
        chk("mid_r_low", 32'(r), 0);
        chk("mid_busy", 32'(busy), 1);
        @(negedge clk);
        s_prev = s;
        r_prev = r;
        repeat (2) tick();
        chk("mid_nodone", 32'(done_cnt - dn0), 0);
        chk("mid_err", 32'(err), 0);
        release_and_check_init("init3");

        // Random traffic against transaction-level model
        accepts = 0;
        exp_pulses = 0;
        p0 = s_pulses + r_pulses;
        dn0 = done_cnt;
        budget = 20000;
        while ((accepts < 1000 || exp_done_q.size() > 0) && budget > 0) begin
            budget--;
            d_valid = (accepts < 1000) && ($urandom_range(0, 3) != 0);
            d_in = $urandom_range(0, 1);
            acc = d_valid && d_ready;
            if (acc) begin
                att = (d_in == q_model) ? 0 : 1;
                exp_done_q.push_back(cyc + exp_latency(att));
                exp_val_q.push_back(d_in);
                exp_pulses += att;
                q_model = d_in;
                accepts++;
            end
            tick();
            if (done) begin
                chk("rnd_spurious_done", 32'(exp_done_q.size() > 0), 1);
                if (exp_done_q.size() > 0) begin
                    edc = exp_done_q.pop_front();
                    ev = exp_val_q.pop_front();
                    chk("rnd_done_cycle", 32'(cyc), 32'(edc));
                    chk("rnd_q", 32'(q_fb), 32'(ev));
                end
            end
        end
        d_valid = 1'b0;
        chk("rnd_budget", 32'(budget > 0), 1);
        chk("rnd_accepts", 32'(accepts), 1000);
        chk("rnd_dones", 32'(done_cnt - dn0), 1000);
        chk("rnd_pulses", 32'(s_pulses + r_pulses - p0), 32'(exp_pulses));
        chk("rnd_err", 32'(err), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
